// File: rtl/operand_scoreboard.sv
// Issue-side register scoreboard: per-register pending/countdown tracking, RAW/WAW/full stalls.
// Optional SCOREBOARD_PERF_COUNTER_EN adds saturating stall counters.
module operand_scoreboard #(
  parameter  int LAT_W           = 3,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  input  logic [4:0]       issue_reg_src_A_i,
  input  logic [4:0]       issue_reg_src_B_i,
  input  logic [4:0]       issue_reg_dest_i,
  input  logic             issue_writes_i,
  input  logic [LAT_W-1:0] issue_latency_i,
  input  logic             writeback_valid_i,
  input  logic [4:0]       writeback_reg_dest_i,
  output logic             issue_stall_o,
  output logic [OUT_W-1:0] outstanding_o
`ifdef SCOREBOARD_PERF_COUNTER_EN
  ,
  output logic [31:0]      stall_cycles_o,
  output logic [31:0]      raw_stall_cycles_o
`endif
);

  logic [31:0]      pending_q, pending_d;
  logic [LAT_W-1:0] cnt_q [32];
  logic [LAT_W-1:0] cnt_d [32];
  logic [OUT_W-1:0] out_q, out_d;

  logic raw_a, raw_b, waw, full;
  logic accept, acc_wr, wb_hit;

  // A pending register with an expired countdown is served by the bypass path.
  assign raw_a  = pending_q[issue_reg_src_A_i] && (cnt_q[issue_reg_src_A_i] != '0);
  assign raw_b  = pending_q[issue_reg_src_B_i] && (cnt_q[issue_reg_src_B_i] != '0);
  assign waw    = issue_writes_i && pending_q[issue_reg_dest_i];
  assign full   = issue_writes_i && (issue_reg_dest_i != 5'd0) &&
                  (out_q == OUT_W'(MAX_OUTSTANDING));

  assign issue_stall_o = flush_i || (issue_valid_i && (raw_a || raw_b || waw || full));
  assign accept        = issue_valid_i && !issue_stall_o;
  assign acc_wr        = accept && issue_writes_i && (issue_reg_dest_i != 5'd0);
  assign wb_hit        = writeback_valid_i && (writeback_reg_dest_i != 5'd0) &&
                         pending_q[writeback_reg_dest_i];
  assign outstanding_o = out_q;

  always_comb begin
    pending_d = pending_q;
    out_d     = out_q;
    for (int r = 0; r < 32; r++) cnt_d[r] = cnt_q[r];

    if (flush_i) begin
      pending_d = '0;
      out_d     = '0;
      for (int r = 0; r < 32; r++) cnt_d[r] = '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (pending_q[r] && (cnt_q[r] != '0)) cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      if (wb_hit) begin
        pending_d[writeback_reg_dest_i] = 1'b0;
        cnt_d[writeback_reg_dest_i]     = '0;
      end
      // WAW stall keeps the accepted destination distinct from any writeback hit.
      if (acc_wr) begin
        pending_d[issue_reg_dest_i] = 1'b1;
        cnt_d[issue_reg_dest_i]     = issue_latency_i;
      end
      case ({acc_wr, wb_hit})
        2'b10:   out_d = out_q + OUT_W'(1);
        2'b01:   out_d = out_q - OUT_W'(1);
        default: out_d = out_q;
      endcase
    end
    pending_d[0] = 1'b0;
    cnt_d[0]     = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      out_q     <= '0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      pending_q <= pending_d;
      out_q     <= out_d;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef SCOREBOARD_PERF_COUNTER_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt_q, raw_cnt_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      raw_cnt_q   <= '0;
    end else begin
      if (issue_valid_i && issue_stall_o && !flush_i) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (issue_valid_i && (raw_a || raw_b) && !flush_i) raw_cnt_q <= sat_inc(raw_cnt_q);
    end
  end

  assign stall_cycles_o     = stall_cnt_q;
  assign raw_stall_cycles_o = raw_cnt_q;
`endif

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed bench for operand_scoreboard: time-based reference model checked every cycle
// plus literal expectations at key points of each scenario.
module tb_operand_scoreboard;
  localparam int LAT_W = 3;
  localparam int MAXO  = 8;
  localparam int OUT_W = $clog2(MAXO + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             iv = 1'b0;
  logic [4:0]       sa = '0, sb = '0, dst = '0;
  logic             wr = 1'b0;
  logic [LAT_W-1:0] lat = '0;
  logic             wbv = 1'b0;
  logic [4:0]       wbd = '0;
  logic             stall;
  logic [OUT_W-1:0] outst;

  int checks = 0;
  int errors = 0;

  operand_scoreboard #(.LAT_W(LAT_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .issue_valid_i(iv), .issue_reg_src_A_i(sa), .issue_reg_src_B_i(sb),
    .issue_reg_dest_i(dst), .issue_writes_i(wr), .issue_latency_i(lat),
    .writeback_valid_i(wbv), .writeback_reg_dest_i(wbd),
    .issue_stall_o(stall), .outstanding_o(outst)
  );

  always #5 clk = ~clk;

  // Reference model: a write accepted in cycle t with latency L makes dependents
  // wait while (now - t) <= L; it stays in flight until its writeback.
  int cyc = 0;
  bit m_pend [32];
  int m_t    [32];
  int m_lat  [32];
  int m_out  = 0;

  initial for (int r = 0; r < 32; r++) begin
    m_pend[r] = 1'b0; m_t[r] = 0; m_lat[r] = 0;
  end

  function automatic bit m_hot(input logic [4:0] r);
    return m_pend[r] && ((cyc - m_t[r]) <= m_lat[r]);
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = m_hot(sa) || m_hot(sb) || (wr && m_pend[dst]) ||
         (wr && dst != 0 && m_out == MAXO);
    return flush || (iv && hz);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      m_out = 0;
    end else begin
      bit acc, wrhit, wbhit;
      acc   = iv && !m_stall();
      wrhit = !flush && acc && wr && dst != 0;
      wbhit = !flush && wbv && wbd != 0 && m_pend[wbd];
      if (flush) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        m_out = 0;
      end else begin
        if (wbhit) begin m_pend[wbd] = 1'b0; m_out--; end
        if (wrhit) begin
          m_pend[dst] = 1'b1; m_t[dst] = cyc; m_lat[dst] = int'(lat); m_out++;
        end
      end
      cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("model_stall", int'(stall), int'(m_stall()));
    chk("model_outstanding", int'(outst), m_out);
  end

  task automatic step(input bit v, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input bit w, input int l,
                      input bit wv, input logic [4:0] wd, input bit fl);
    @(posedge clk); #1;
    iv = v; sa = a; sb = b; dst = d; wr = w; lat = LAT_W'(l);
    wbv = wv; wbd = wd; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input logic [4:0] r);
    step(0, 0, 0, 0, 0, 0, 1, r, 0);
  endtask

  initial begin
    #3;
    chk("rst_out", int'(outst), 0);
    chk("rst_stall", int'(stall), 0);
    flush = 1'b1; #1;
    chk("rst_stall_flush", int'(stall), 1);
    flush = 1'b0; #1;
    #16 rst_n = 1'b1;

    // latency 0: dependent issues back to back
    step(1, 0, 0, 5, 1, 0, 0, 0, 0);
    chk("lat0_first", int'(stall), 0);
    step(1, 5, 0, 6, 1, 0, 0, 0, 0);
    chk("lat0_dep_stall", int'(stall), 0);
    chk("lat0_out1", int'(outst), 1);
    idle();
    chk("lat0_out2", int'(outst), 2);
    wb(5); wb(6); idle();
    chk("lat0_drain", int'(outst), 0);

    // latency 3: src B waits three cycles
    step(1, 0, 0, 7, 1, 3, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 7, 0, 0, 0, 0, 0, 0);
      chk($sformatf("lat3_stall_c%0d", k), int'(stall), 1);
    end
    step(1, 0, 7, 0, 0, 0, 0, 0, 0);
    chk("lat3_accept_c4", int'(stall), 0);
    idle();
    chk("lat3_out", int'(outst), 1);
    wb(7); idle();
    chk("lat3_drain", int'(outst), 0);

    // WAW: second write to x9 waits for writeback
    step(1, 0, 0, 9, 1, 2, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 9, 1, 0, 0, 0, 0);
      chk($sformatf("waw_stall_%0d", k), int'(stall), 1);
    end
    step(1, 0, 0, 9, 1, 0, 1, 9, 0);
    chk("waw_stall_wb_cycle", int'(stall), 1);
    step(1, 0, 0, 9, 1, 0, 0, 0, 0);
    chk("waw_accept", int'(stall), 0);
    wb(9);
    idle();
    chk("waw_drain", int'(outst), 0);

    // full: eight writes in flight block a ninth
    for (int r = 1; r <= 8; r++) step(1, 0, 0, 5'(r), 1, 0, 0, 0, 0);
    step(1, 0, 0, 10, 1, 0, 0, 0, 0);
    chk("full_stall", int'(stall), 1);
    chk("full_out", int'(outst), 8);
    step(1, 0, 0, 10, 1, 0, 1, 1, 0);
    chk("full_stall_wb", int'(stall), 1);
    step(1, 0, 0, 10, 1, 0, 0, 0, 0);
    chk("full_accept", int'(stall), 0);
    chk("full_out7", int'(outst), 7);
    idle();
    chk("full_out8", int'(outst), 8);
    for (int r = 2; r <= 8; r++) wb(5'(r));
    wb(10); idle();
    chk("full_drain", int'(outst), 0);

    // flush with four pending, x3 counting from 5
    step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 2, 1, 1, 0, 0, 0);
    step(1, 0, 0, 4, 1, 2, 0, 0, 0);
    step(1, 0, 0, 3, 1, 5, 0, 0, 0);
    step(1, 3, 0, 11, 1, 0, 1, 1, 1);
    chk("flush_stall", int'(stall), 1);
    chk("flush_out_before", int'(outst), 4);
    step(1, 3, 0, 12, 1, 0, 0, 0, 0);
    chk("postflush_stall", int'(stall), 0);
    chk("postflush_out", int'(outst), 0);
    wb(12); idle();

    // async reset in the middle of a countdown
    step(1, 0, 0, 13, 1, 7, 0, 0, 0);
    step(1, 13, 0, 0, 0, 0, 0, 0, 0);
    chk("prereset_stall", int'(stall), 1);
    chk("prereset_out", int'(outst), 1);
    rst_n = 1'b0; #1;
    chk("async_rst_out", int'(outst), 0);
    chk("async_rst_stall", int'(stall), 0);
    #1 rst_n = 1'b1;
    step(1, 13, 0, 0, 0, 0, 0, 0, 0);
    chk("postreset_stall", int'(stall), 0);

    // x0 never becomes pending; stray writebacks ignored
    step(1, 0, 0, 0, 1, 7, 0, 0, 0);
    chk("x0_write_stall", int'(stall), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_read_stall", int'(stall), 0);
    chk("x0_out", int'(outst), 0);
    wb(20); wb(0); idle();
    chk("stray_wb_out", int'(outst), 0);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end
endmodule
